// File: rtl/msx_ram_arbiter_pkg.sv
// Shared types for the MSX external RAM arbiter: region table entry, FSM states
// and requester identifiers.
package msx_ram_arbiter_pkg;

  localparam int unsigned RAM_AW        = 27;
  localparam int unsigned RAM_PAGE_BITS = 14;
  localparam int unsigned RAM_REGIONS   = 16;
  localparam int unsigned LOOKUP_SIZE_W = 16;

  localparam logic [7:0] DOUT_EMPTY = 8'hFF;

  // Same layout as MSX::lookup_RAM_t: base address, size in pages, read-only flag.
  typedef struct packed {
    logic [RAM_AW-1:0]        addr;
    logic [LOOKUP_SIZE_W-1:0] size;
    logic                     ro;
  } lookup_RAM_t;

  typedef enum logic [1:0] {
    ARB_IDLE,
    ARB_ISSUE,
    ARB_WAIT,
    ARB_ACK
  } arb_state_t;

  typedef enum logic [1:0] {
    SRC_NONE,
    SRC_LD,
    SRC_FL,
    SRC_CPU
  } arb_src_t;

endpackage

// File: rtl/msx_ram_arbiter_if.sv
// Requester and RAM-side signals of the RAM arbiter. master = requesters plus
// RAM controller (the environment), slave = the arbiter.
interface msx_ram_arbiter_if #(
  parameter int unsigned AW    = 27,
  parameter int unsigned REF_W = 4
);

  logic             cpu_req;
  logic             cpu_we;
  logic [REF_W-1:0] cpu_ref;
  logic [AW-1:0]    cpu_offset;
  logic [7:0]       cpu_din;
  logic [7:0]       cpu_dout;
  logic             cpu_ack;

  logic             ld_req;
  logic [AW-1:0]    ld_addr;
  logic [7:0]       ld_din;
  logic             ld_ack;

  logic             fl_req;
  logic             fl_we;
  logic [AW-1:0]    fl_addr;
  logic [7:0]       fl_din;
  logic [7:0]       fl_dout;
  logic             fl_ack;

  logic [AW-1:0]    ram_addr;
  logic [7:0]       ram_din;
  logic             ram_rd;
  logic             ram_we;
  logic [7:0]       ram_dout;
  logic             ram_ready;

  modport master (
    output cpu_req, cpu_we, cpu_ref, cpu_offset, cpu_din,
    input  cpu_dout, cpu_ack,
    output ld_req, ld_addr, ld_din,
    input  ld_ack,
    output fl_req, fl_we, fl_addr, fl_din,
    input  fl_dout, fl_ack,
    input  ram_addr, ram_din, ram_rd, ram_we,
    output ram_dout, ram_ready
  );

  modport slave (
    input  cpu_req, cpu_we, cpu_ref, cpu_offset, cpu_din,
    output cpu_dout, cpu_ack,
    input  ld_req, ld_addr, ld_din,
    output ld_ack,
    input  fl_req, fl_we, fl_addr, fl_din,
    output fl_dout, fl_ack,
    output ram_addr, ram_din, ram_rd, ram_we,
    input  ram_dout, ram_ready
  );

endinterface

// File: rtl/msx_ram_xlate.sv
// Region-relative to absolute address translation with bounds check and
// write-protect flag. Purely combinational.
module msx_ram_xlate
  import msx_ram_arbiter_pkg::*;
#(
  parameter int unsigned PAGE_BITS = RAM_PAGE_BITS,
  parameter int unsigned AW        = RAM_AW
) (
  input  lookup_RAM_t   entry,
  input  logic [AW-1:0] offset,
  output logic [AW-1:0] abs_addr,
  output logic          hit,
  output logic          ro
);

  localparam int unsigned CW = AW + LOOKUP_SIZE_W;

  logic [CW-1:0] page_ext;
  logic [CW-1:0] size_ext;

  // Both sides widened so the page index never truncates; size 0 can never hit.
  always_comb begin
    page_ext = CW'(offset >> PAGE_BITS);
    size_ext = CW'(entry.size);
    hit      = page_ext < size_ext;
    abs_addr = AW'(entry.addr) + offset;
    ro       = entry.ro;
  end

endmodule

// File: rtl/msx_ram_arbiter.sv
// Arbitrates the single external RAM port between loader, flash and CPU
// requesters; CPU accesses are translated through the region table.
module msx_ram_arbiter
  import msx_ram_arbiter_pkg::*;
#(
  parameter int unsigned REGIONS   = RAM_REGIONS,
  parameter int unsigned PAGE_BITS = RAM_PAGE_BITS,
  parameter int unsigned AW        = RAM_AW
) (
  input  logic               clk,
  input  logic               reset_n,
  input  lookup_RAM_t        lookup_RAM [REGIONS],
  msx_ram_arbiter_if.slave   bus
);

  arb_state_t    state;
  arb_state_t    state_nxt;
  arb_src_t      src;
  arb_src_t      grant;
  logic          rr_cpu;
  logic          we_q;
  logic [AW-1:0] addr_q;
  logic [7:0]    din_q;
  logic [7:0]    cpu_dout_q;
  logic [7:0]    fl_dout_q;

  lookup_RAM_t   entry;
  logic [AW-1:0] xl_addr;
  logic          xl_hit;
  logic          xl_ro;
  logic          cpu_direct;

  assign entry = lookup_RAM[bus.cpu_ref];

  msx_ram_xlate #(
    .PAGE_BITS (PAGE_BITS),
    .AW        (AW)
  ) u_xlate (
    .entry    (entry),
    .offset   (bus.cpu_offset),
    .abs_addr (xl_addr),
    .hit      (xl_hit),
    .ro       (xl_ro)
  );

  // Loader always wins; cpu/fl contention resolved by the round-robin pointer.
  always_comb begin
    grant = SRC_NONE;
    if (bus.ld_req)
      grant = SRC_LD;
    else if (bus.cpu_req && bus.fl_req)
      grant = rr_cpu ? SRC_CPU : SRC_FL;
    else if (bus.cpu_req)
      grant = SRC_CPU;
    else if (bus.fl_req)
      grant = SRC_FL;
    cpu_direct = !xl_hit || (bus.cpu_we && xl_ro);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      state <= ARB_IDLE;
    else
      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ARB_IDLE: begin
        if (grant != SRC_NONE)
          state_nxt = (grant == SRC_CPU && cpu_direct) ? ARB_ACK : ARB_ISSUE;
      end
      ARB_ISSUE: state_nxt = ARB_WAIT;
      ARB_WAIT:  if (bus.ram_ready) state_nxt = ARB_ACK;
      ARB_ACK:   state_nxt = ARB_IDLE;
      default:   state_nxt = ARB_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      src        <= SRC_NONE;
      rr_cpu     <= 1'b1;
      we_q       <= 1'b0;
      addr_q     <= '0;
      din_q      <= '0;
      cpu_dout_q <= DOUT_EMPTY;
      fl_dout_q  <= DOUT_EMPTY;
    end else begin
      if (state == ARB_IDLE && grant != SRC_NONE) begin
        src <= grant;
        case (grant)
          SRC_LD: begin
            addr_q <= bus.ld_addr;
            din_q  <= bus.ld_din;
            we_q   <= 1'b1;
          end
          SRC_FL: begin
            addr_q <= bus.fl_addr;
            din_q  <= bus.fl_din;
            we_q   <= bus.fl_we;
            rr_cpu <= 1'b1;
          end
          SRC_CPU: begin
            addr_q <= xl_addr;
            din_q  <= bus.cpu_din;
            we_q   <= bus.cpu_we;
            rr_cpu <= 1'b0;
            // Miss reads return open-bus FF; blocked writes leave dout alone.
            if (!xl_hit && !bus.cpu_we)
              cpu_dout_q <= DOUT_EMPTY;
          end
          default: ;
        endcase
      end
      if (state == ARB_WAIT && bus.ram_ready && !we_q) begin
        if (src == SRC_CPU) cpu_dout_q <= bus.ram_dout;
        if (src == SRC_FL)  fl_dout_q  <= bus.ram_dout;
      end
    end
  end

  assign bus.ram_addr = addr_q;
  assign bus.ram_din  = din_q;
  assign bus.ram_rd   = (state == ARB_ISSUE) && !we_q;
  assign bus.ram_we   = (state == ARB_ISSUE) &&  we_q;
  assign bus.ld_ack   = (state == ARB_ACK) && (src == SRC_LD);
  assign bus.fl_ack   = (state == ARB_ACK) && (src == SRC_FL);
  assign bus.cpu_ack  = (state == ARB_ACK) && (src == SRC_CPU);
  assign bus.cpu_dout = cpu_dout_q;
  assign bus.fl_dout  = fl_dout_q;

endmodule

// File: doc/msx_ram_arbiter.md
Name: msx_ram_arbiter

Overview:
- Shares the single external RAM port between three requesters: ROM/config loader (ld), flash/SRAM writer (fl) and CPU slot accesses (cpu).
- CPU accesses are region-relative. A region index selects one entry of the lookup_RAM table, which translates it to an absolute 27-bit address, bounds-checks it and enforces write protection.
- Sits between the slot/mapper logic and the SDRAM controller wrapper.

Parameters:
- REGIONS, 16, number of lookup_RAM entries; cpu_ref width = $clog2(REGIONS).
- PAGE_BITS, 14, log2 of the region size unit (16 KB pages).
- AW, 27, RAM address width.

Ports:
- clk  in  1  system clock.
- reset_n  in  1  reset, asynchronous, active-low.
- lookup_RAM  in  REGIONS x MSX::lookup_RAM_t  region table: addr = base, size = pages, ro = read-only.
- cpu_req  in  1  CPU request, level.
- cpu_we  in  1  1 = write.
- cpu_ref  in  4  region index.
- cpu_offset  in  AW  byte offset within region.
- cpu_din  in  8  write data.
- cpu_dout  out  8  read data.
- cpu_ack  out  1  one-cycle completion.
- ld_req  in  1  loader write request.
- ld_addr  in  AW  absolute address.
- ld_din  in  8  write data.
- ld_ack  out  1  completion.
- fl_req  in  1  flash request.
- fl_we  in  1  1 = write.
- fl_addr  in  AW  absolute address.
- fl_din  in  8  write data.
- fl_dout  out  8  read data.
- fl_ack  out  1  completion.
- ram_addr  out  AW  RAM address.
- ram_din  out  8  RAM write data.
- ram_rd  out  1  one-cycle read strobe.
- ram_we  out  1  one-cycle write strobe.
- ram_dout  in  8  RAM read data, valid with ram_ready.
- ram_ready  in  1  RAM completion.

Behaviour:
- Reset (async, reset_n low): state IDLE; all acks, ram_rd and ram_we are 0; ram_addr 0; ram_din 0; cpu_dout 8'hFF; fl_dout 8'hFF; round-robin pointer favours cpu. Reset mid-transaction abandons it with no ack.
- Handshake: req is level and is held with stable fields until its ack. Ack is high for exactly one cycle. The requester deasserts req on the edge where it samples ack, otherwise the request is treated as a new one.
- States: IDLE, ISSUE, WAIT, ACK.
  - IDLE: if any req is high, grant and latch the requester, address, data and we. Next state is ISSUE, or ACK for a CPU miss or blocked write.
  - ISSUE: ram_rd or ram_we = 1 for this cycle only; ram_addr and ram_din are stable from ISSUE through WAIT. Next state WAIT.
  - WAIT: ram_ready is sampled only here. When high, latch ram_dout into the granted requester's dout (reads only), go to ACK. Otherwise stay; there is no timeout.
  - ACK: the granted ack = 1. Next state IDLE.
- Priority: ld beats everything. Between cpu and fl, round-robin: the pointer flips to the other requester after each granted cpu/fl transaction. ld grants do not move the pointer.
- Simultaneous requests: only one grant per IDLE cycle; the losers stay pending.
- CPU translation (combinational in IDLE, result registered at grant):
  - entry = lookup_RAM[cpu_ref].
  - hit = (cpu_offset >> PAGE_BITS) < entry.size, using zero-extended compare; size 0 means never hit.
  - ram_addr = entry.addr + cpu_offset, truncated to AW bits (wrap-around permitted, not flagged).
- CPU miss read: no RAM access; cpu_dout = 8'hFF; ack in the cycle after grant.
- CPU write to a region with ro = 1, or a miss write: dropped with no RAM strobe; acked in the cycle after grant; cpu_dout unchanged.
- Latency, with the request first high in cycle 0 and the arbiter idle:
  - RAM access: ISSUE in cycle 1, WAIT from cycle 2; ack in the cycle after ram_ready is seen, minimum cycle 3.
  - Miss or blocked write: ack in cycle 1.
- A dout holds its value until the next read for that requester completes.
- lookup_RAM is sampled only at grant; changes during a transaction do not affect it.

Decomposition:
- Shared package additions: enum arb_state_t {ARB_IDLE, ARB_ISSUE, ARB_WAIT, ARB_ACK}; enum arb_src_t {SRC_NONE, SRC_LD, SRC_FL, SRC_CPU}; constant RAM_PAGE_BITS = 14. lookup_RAM_t is reused unchanged.
- One combinational sub-module, msx_ram_xlate: entry, offset -> abs_addr, hit, ro. It is reused by the future DMA path.

Test Plan:
- Region 2 = {addr 27'h0100000, size 2, ro 0}; CPU read ref 2, offset 27'h0_7FFF; ram_ready high in first WAIT cycle, ram_dout 8'h5A -> ram_rd pulse at 27'h0107FFF in cycle 1; cpu_ack in cycle 3; cpu_dout 8'h5A.
- Same region, CPU read offset 27'h0_8000 -> no ram_rd; cpu_ack in cycle 1; cpu_dout 8'hFF.
- Region 3 with ro 1; CPU write 8'h11 -> no ram_we; cpu_ack in cycle 1. Same write with ro 0 -> one ram_we pulse with ram_din 8'h11.
- ld_req, fl_req and cpu_req all high in cycle 0, ram_ready constant 1 -> acks in order ld, cpu, fl. Then fl and cpu re-requesting continuously -> grants alternate fl, cpu, fl.
- Flash read with ram_ready held low 10 cycles -> ram_addr stable throughout; fl_ack exactly one cycle after ram_ready rises.
- reset_n low during WAIT -> all strobes and acks 0 and doubles FF immediately (asynchronous); after release the state is IDLE and a new CPU request completes normally.
